// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC thermometer encoder and the channel readout.
package tdc_pkg;

  // Bit positions inside the two-bit {overflow, bubble} flag bus.
  localparam int unsigned FLAG_BUBBLE = 0;
  localparam int unsigned FLAG_OVF    = 1;

  function automatic int unsigned code_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tdc_therm_encode_comb.sv
// Combinational thermometer encoder: 1-based index of the highest set bit,
// plus all-ones overflow and bubble (a zero below the highest one) flags.
module tdc_therm_encode_comb
  import tdc_pkg::*;
#(
  parameter int unsigned N = 40,
  parameter int unsigned W = code_width(N)
) (
  input  logic [N-1:0] d,
  output logic [W-1:0] code,
  output logic         overflow,
  output logic         bubble
);

  logic zero_seen;

  // Scan upward: any one found after an earlier zero marks a bubble.
  always_comb begin
    code      = '0;
    bubble    = 1'b0;
    zero_seen = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (d[i]) begin
        code = W'(i + 1);
        if (zero_seen) begin
          bubble = 1'b1;
        end
      end else begin
        zero_seen = 1'b1;
      end
    end
  end

  assign overflow = &d;

endmodule

// File: rtl/tdc_therm_encoder_pipe.sv
// Two-stage thermometer-to-binary encoder for a TDC tap vector, with
// valid/ready backpressure and a tri-stated readout bus.
module tdc_therm_encoder_pipe
  import tdc_pkg::*;
#(
  parameter int unsigned N = 40,
  parameter int unsigned W = code_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] taps,
  input  logic         polarity,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         out_ready,
  input  logic         sel,
  output logic         out_valid,
  output logic [W-1:0] code,
  output logic         overflow,
  output logic         bubble,
  output logic [W-1:0] code_z,
  output logic [1:0]   flags_z
);

  logic         s1_valid;
  logic [N-1:0] s1_d;
  logic         s2_valid;
  logic         s2_advance;
  logic         accept;
  logic [W-1:0] enc_code;
  logic         enc_overflow;
  logic         enc_bubble;
  logic [1:0]   flags;

  // Stage 1 moves on when stage 2 is empty or handing its result off now.
  assign s2_advance = s1_valid & (~s2_valid | out_ready);
  assign in_ready   = ~s1_valid | s2_advance;
  assign accept     = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_d     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_d     <= taps ^ {N{polarity}};
    end else if (s2_advance) begin
      s1_valid <= 1'b0;
    end
  end

  tdc_therm_encode_comb #(
    .N (N),
    .W (W)
  ) u_encode (
    .d        (s1_d),
    .code     (enc_code),
    .overflow (enc_overflow),
    .bubble   (enc_bubble)
  );

  // Result registers only reload on advance, so they hold through a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      code     <= '0;
      overflow <= 1'b0;
      bubble   <= 1'b0;
    end else if (s2_advance) begin
      s2_valid <= 1'b1;
      code     <= enc_code;
      overflow <= enc_overflow;
      bubble   <= enc_bubble;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

  always_comb begin
    flags              = '0;
    flags[FLAG_OVF]    = overflow;
    flags[FLAG_BUBBLE] = bubble;
  end

  assign code_z  = sel ? {W{1'bz}} : code;
  assign flags_z = sel ? 2'bzz : flags;

endmodule

// File: tb/tb_tdc_therm_encoder_pipe.sv
// Scoreboard bench for tdc_therm_encoder_pipe: expected results are queued on
// acceptance and compared when the DUT hands a result off.
module tb_tdc_therm_encoder_pipe;

  localparam int N = 40;
  localparam int W = $clog2(N + 1);

  logic         clk;
  logic         rst_n;
  logic [N-1:0] taps;
  logic         polarity;
  logic         in_valid;
  logic         in_ready;
  logic         out_ready;
  logic         sel;
  logic         out_valid;
  logic [W-1:0] code;
  logic         overflow;
  logic         bubble;
  wire  [W-1:0] code_z;
  wire  [1:0]   flags_z;

  int n_checks = 0;
  int n_pass   = 0;
  int n_recv   = 0;

  logic [W+1:0] sb[$];
  logic [W+1:0] got_m;
  logic [W+1:0] exp_m;

  tdc_therm_encoder_pipe #(
    .N (N),
    .W (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .taps      (taps),
    .polarity  (polarity),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .code      (code),
    .overflow  (overflow),
    .bubble    (bubble),
    .code_z    (code_z),
    .flags_z   (flags_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog elapsed without reaching summary");
    $fatal(1, "watchdog");
  end

  // Reference: highest set index from the top, bubble when popcount != index.
  function automatic logic [W+1:0] model(input logic [N-1:0] t, input logic p);
    logic [N-1:0] d;
    int h;
    int ones;
    d = t ^ {N{p}};
    h = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (d[i] && h == 0) h = i + 1;
    end
    ones = $countones(d);
    return {(ones == N), (ones != h), W'(h)};
  endfunction

  // Result monitor, sampled a few time units before the rising edge.
  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid && out_ready) begin
      got_m = {overflow, bubble, code};
      n_recv++;
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL result unexpected got code=%0d ovf=%0b bub=%0b required none",
                 got_m[W-1:0], got_m[W+1], got_m[W]);
      end else begin
        exp_m = sb.pop_front();
        if (got_m !== exp_m) begin
          $display("FAIL result got code=%0d ovf=%0b bub=%0b required code=%0d ovf=%0b bub=%0b",
                   got_m[W-1:0], got_m[W+1], got_m[W], exp_m[W-1:0], exp_m[W+1], exp_m[W]);
        end else begin
          n_pass++;
        end
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [N-1:0] t, input logic p);
    bit done = 1'b0;
    taps     = t;
    polarity = p;
    in_valid = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      #3;
      if (in_ready) begin
        sb.push_back(model(t, p));
        done = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL send_timeout got in_ready=0 required in_ready=1 within 50 cycles");
    end
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (sb.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    n_checks++;
    if (sb.size() != 0) $display("FAIL %s_drain got pending=%0d required 0", name, sb.size());
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    taps      = '0;
    polarity  = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sel       = 1'b0;
    #3;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (code !== '0) $display("FAIL reset_code got %0d required 0", code);
    else n_pass++;
    n_checks++;
    if ({overflow, bubble} !== 2'b00) $display("FAIL reset_flags got %b required 00", {overflow, bubble});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b required 1", in_ready);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_clean();
    send(40'h0, 1'b0);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL latency_early got out_valid=%b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL latency_two got out_valid=%b required 1", out_valid);
    else n_pass++;
    @(negedge clk);
    send(40'h1, 1'b0);
    send(40'h7, 1'b0);
    send(40'h7F_FFFF_FFFF, 1'b0);
    drain("clean");
  endtask

  task automatic test_overflow_polarity();
    send(40'hFF_FFFF_FFFF, 1'b0);
    send(40'hFF_FFFF_FFF0, 1'b1);
    send(40'h00_0000_0003, 1'b0);
    drain("overflow_polarity");
  endtask

  task automatic test_bubble();
    send(40'h0B, 1'b0);
    send(40'h2000_0001, 1'b0);
    drain("bubble");
  endtask

  task automatic test_backpressure();
    logic [N-1:0] vals[5] = '{40'h3, 40'h1F, 40'h0B, 40'hFF_FFFF_FFFF, 40'hF0};
    int recv0 = n_recv;
    fork
      begin
        for (int i = 0; i < 5; i++) send(vals[i], 1'b0);
      end
      begin
        bit seen = 1'b0;
        logic [W-1:0] held;
        for (int c = 0; c < 20 && !seen; c++) begin
          @(negedge clk);
          #1;
          if (out_valid) seen = 1'b1;
        end
        n_checks++;
        if (!seen) $display("FAIL bp_first_result got none required out_valid within 20 cycles");
        else n_pass++;
        if (seen) begin
          out_ready = 1'b0;
          held = code;
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || code !== held)
              $display("FAIL bp_hold got valid=%b code=%0d required valid=1 code=%0d",
                       out_valid, code, held);
            else n_pass++;
            n_checks++;
            if (in_ready !== 1'b0) $display("FAIL bp_in_ready got %b required 0", in_ready);
            else n_pass++;
            n_checks++;
            if (code_z !== held) $display("FAIL bp_code_z got %0d required %0d", code_z, held);
            else n_pass++;
          end
          out_ready = 1'b1;
        end
      end
    join
    drain("backpressure");
    n_checks++;
    if (n_recv - recv0 != 5) $display("FAIL bp_count got %0d required 5", n_recv - recv0);
    else n_pass++;
  endtask

  task automatic test_tristate();
    send(40'h0B, 1'b0);
    drain("tristate");
    sel = 1'b0;
    #1;
    n_checks++;
    if (code_z !== 6'd4 || flags_z !== 2'b01)
      $display("FAIL tri_driven got code_z=%0d flags_z=%b required 4 01", code_z, flags_z);
    else n_pass++;
    sel = 1'b1;
    #1;
    n_checks++;
    if (!(code_z === 6'bzzzzzz || code_z === 6'd0))
      $display("FAIL tri_code_float got %b required z", code_z);
    else n_pass++;
    n_checks++;
    if (!(flags_z === 2'bzz || flags_z === 2'b00))
      $display("FAIL tri_flags_float got %b required z", flags_z);
    else n_pass++;
    sel = 1'b0;
    #1;
    n_checks++;
    if (code_z !== 6'd4) $display("FAIL tri_redrive got code_z=%0d required 4", code_z);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send(40'hFF_FFFF_FFFF, 1'b0);
    send(40'h1F, 1'b0);
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0)
      $display("FAIL ar_full got valid=%b in_ready=%b required 1 0", out_valid, in_ready);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL ar_out_valid got %b required 0", out_valid);
    else n_pass++;
    n_checks++;
    if (code !== '0 || overflow !== 1'b0)
      $display("FAIL ar_code got code=%0d ovf=%b required 0 0", code, overflow);
    else n_pass++;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    send(40'h7, 1'b0);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) $display("FAIL ar_latency_early got %b required 0", out_valid);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b1 || code !== 6'd3)
      $display("FAIL ar_first got valid=%b code=%0d required 1 3", out_valid, code);
    else n_pass++;
    @(negedge clk);
    drain("async_reset");
  endtask

  initial begin
    test_reset();
    test_clean();
    test_overflow_polarity();
    test_bubble();
    test_backpressure();
    test_tristate();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
